// File: rtl/ledstring_rx_pkg.sv
// Shared word constants, field positions and receiver state encoding for the
// APA102-style LED string receiver.
package ledstring_pkg;

    localparam int WORD_BITS = 32;

    localparam logic [WORD_BITS-1:0] START_WORD = 32'h0000_0000;
    localparam logic [WORD_BITS-1:0] END_WORD   = 32'hFFFF_FFFF;
    localparam logic [2:0]           PIX_HDR    = 3'b111;

    localparam int HDR_MSB = 31;
    localparam int HDR_LSB = 29;
    localparam int GLO_MSB = 28;
    localparam int GLO_LSB = 24;
    localparam int BLU_MSB = 23;
    localparam int BLU_LSB = 16;
    localparam int GRN_MSB = 15;
    localparam int GRN_LSB = 8;
    localparam int RED_MSB = 7;
    localparam int RED_LSB = 0;

    typedef enum logic {
        HUNT = 1'b0,
        WORD = 1'b1
    } rx_state_t;

endpackage

// File: rtl/ledstring_rx_if.sv
// Pixel valid/ack handshake between the LED string receiver (master) and its
// consumer (slave).
interface ledstring_rx_if #(
    parameter int PIX_W = 8
);
    logic [4:0]       pix_glo;
    logic [7:0]       pix_red;
    logic [7:0]       pix_grn;
    logic [7:0]       pix_blu;
    logic [PIX_W-1:0] pix_idx;
    logic             valid;
    logic             ack;

    modport master (
        output pix_glo, pix_red, pix_grn, pix_blu, pix_idx, valid,
        input  ack
    );

    modport slave (
        input  pix_glo, pix_red, pix_grn, pix_blu, pix_idx, valid,
        output ack
    );
endinterface

// File: rtl/ledstring_rx_sync.sv
// Synchroniser chains for led_clk/led_data plus rising-edge detector; bit_stb
// marks the cycle in which bit_val holds the freshly clocked data bit.
module ledstring_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic led_clk,
    input  logic led_data,
    output logic bit_stb,
    output logic bit_val
);
    logic [SYNC_STAGES-1:0] clk_p0;
    logic [SYNC_STAGES-1:0] data_p0;
    logic                   clk_p1;

    // Stage p0: synchroniser chains. Left free-running through reset so that
    // releasing rst can never fabricate an edge from a stale history bit.
    always_ff @(posedge clk) begin
        clk_p0  <= {clk_p0[SYNC_STAGES-2:0], led_clk};
        data_p0 <= {data_p0[SYNC_STAGES-2:0], led_data};
    end

    // Stage p1: previous synchronised clock level for edge detection
    always_ff @(posedge clk) begin
        clk_p1 <= clk_p0[SYNC_STAGES-1];
    end

    assign bit_stb = clk_p0[SYNC_STAGES-1] & ~clk_p1;
    assign bit_val = data_p0[SYNC_STAGES-1];

endmodule

// File: rtl/ledstring_rx.sv
// APA102-style LED string receiver: frames 32-bit words and presents pixels on
// a valid/ack interface. Define LEDSTRING_RX_STATS_EN for err/drop/frame counters.
module ledstring_rx
    import ledstring_pkg::*;
#(
    parameter int PIX_W       = 8,
    parameter int TIMEOUT     = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           led_clk,
    input  logic           led_data,
    ledstring_rx_if.master pix,
    output logic           frame_start,
    output logic           frame_end,
    output logic           overrun
`ifdef LEDSTRING_RX_STATS_EN
    ,
    output logic [7:0]     err_cnt,
    output logic [7:0]     drop_cnt,
    output logic [15:0]    frame_cnt
`endif
);
    localparam int                IDLE_W   = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

    function automatic logic [PIX_W-1:0] sat_idx(input logic [PIX_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef LEDSTRING_RX_STATS_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
`endif

    logic                 bit_stb;
    logic                 bit_val;
    rx_state_t            state;
    logic [4:0]           zero_cnt;
    logic [4:0]           bit_cnt;
    logic                 word_rdy;
    logic [WORD_BITS-1:0] shift_reg;
    logic [IDLE_W-1:0]    idle_cnt;
    logic [PIX_W-1:0]     idx_cnt;

    ledstring_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .led_clk  (led_clk),
        .led_data (led_data),
        .bit_stb  (bit_stb),
        .bit_val  (bit_val)
    );

    // Shift register is pure datapath: bit_cnt/word_rdy decide when it is valid
    always_ff @(posedge clk) begin
        if (bit_stb) shift_reg <= {shift_reg[WORD_BITS-2:0], bit_val};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            zero_cnt    <= '0;
            bit_cnt     <= '0;
            word_rdy    <= 1'b0;
            idle_cnt    <= '0;
            idx_cnt     <= '0;
            pix.pix_glo <= '0;
            pix.pix_red <= '0;
            pix.pix_grn <= '0;
            pix.pix_blu <= '0;
            pix.pix_idx <= '0;
            pix.valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            overrun     <= 1'b0;
`ifdef LEDSTRING_RX_STATS_EN
            err_cnt     <= '0;
            drop_cnt    <= '0;
            frame_cnt   <= '0;
`endif
        end else begin
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            word_rdy    <= 1'b0;

            if (bit_stb)                   idle_cnt <= '0;
            else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;

            // A same-cycle pixel load below overrides this clear
            if (pix.valid && pix.ack) pix.valid <= 1'b0;

            case (state)
                HUNT: begin
                    if (bit_stb) begin
                        if (bit_val) begin
                            zero_cnt <= '0;
                        end else if (zero_cnt == 5'd31) begin
                            frame_start <= 1'b1;
                            idx_cnt     <= '0;
                            bit_cnt     <= '0;
                            zero_cnt    <= '0;
                            state       <= WORD;
                        end else begin
                            zero_cnt <= zero_cnt + 5'd1;
                        end
                    end
                end

                WORD: begin
                    if (bit_stb) begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd31) word_rdy <= 1'b1;
                    end

                    if (word_rdy) begin
                        if (shift_reg == START_WORD) begin
                            frame_start <= 1'b1;
                            idx_cnt     <= '0;
                        end else if (shift_reg == END_WORD) begin
                            frame_end <= 1'b1;
                            zero_cnt  <= '0;
                            state     <= HUNT;
`ifdef LEDSTRING_RX_STATS_EN
                            frame_cnt <= sat_inc16(frame_cnt);
`endif
                        end else if (shift_reg[HDR_MSB:HDR_LSB] == PIX_HDR) begin
                            idx_cnt <= sat_idx(idx_cnt);
                            if (!pix.valid || pix.ack) begin
                                pix.pix_glo <= shift_reg[GLO_MSB:GLO_LSB];
                                pix.pix_blu <= shift_reg[BLU_MSB:BLU_LSB];
                                pix.pix_grn <= shift_reg[GRN_MSB:GRN_LSB];
                                pix.pix_red <= shift_reg[RED_MSB:RED_LSB];
                                pix.pix_idx <= idx_cnt;
                                pix.valid   <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
`ifdef LEDSTRING_RX_STATS_EN
                                drop_cnt <= sat_inc8(drop_cnt);
`endif
                            end
                        end else begin
                            zero_cnt <= '0;
                            state    <= HUNT;
`ifdef LEDSTRING_RX_STATS_EN
                            err_cnt  <= sat_inc8(err_cnt);
`endif
                        end
                    end

                    // Stalled string: abandon the partial word and re-acquire
                    if (idle_cnt == IDLE_MAX) begin
                        bit_cnt  <= '0;
                        zero_cnt <= '0;
                        word_rdy <= 1'b0;
                        state    <= HUNT;
`ifdef LEDSTRING_RX_STATS_EN
                        if (bit_cnt != 5'd0) err_cnt <= sat_inc8(err_cnt);
`endif
                    end
                end

                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: doc/ledstring_rx.md
Name: ledstring_rx

Overview:
- APA102-style LED string receiver: the sink end of the clock/data LED protocol.
- Oversamples an external led_clk/led_data pair in the system clock domain and frames 32-bit words.
- Decodes start frames, pixel frames and end frames; presents each pixel on a valid/ack interface.
- Used for loopback verification of the string driver and for daisy-chain sniffing.

Parameters:
- PIX_W, 8, width of the pixel index; the index saturates at 2^PIX_W-1.
- TIMEOUT, 1024, clk cycles without a led_clk rising edge before the receiver drops to HUNT.
- SYNC_STAGES, 2, synchroniser depth applied to both led_clk and led_data (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- led_clk  in  1  LED string clock, asynchronous to clk.
- led_data  in  1  LED string data, asynchronous to clk.
- pix_glo  out  5  global brightness of the held pixel.
- pix_red  out  8  red component of the held pixel.
- pix_grn  out  8  green component of the held pixel.
- pix_blu  out  8  blue component of the held pixel.
- pix_idx  out  PIX_W  position of the held pixel within the frame, first pixel = 0.
- valid  out  1  pixel registers hold an unconsumed pixel.
- ack  in  1  consumer takes the pixel; a transfer occurs when valid & ack.
- frame_start  out  1  one-cycle pulse on each decoded start frame.
- frame_end  out  1  one-cycle pulse on each decoded end frame.
- overrun  out  1  sticky; a pixel was dropped because valid was still high. Cleared only by rst.

Behaviour:
- Clock and reset: single clock domain. rst is synchronous, active-high. On reset: all outputs 0, state HUNT, counters 0.
- Input sampling:
  - led_clk and led_data pass through identical SYNC_STAGES flop chains.
  - A rising edge is detected on the synchronised clock (previous 0, current 1).
  - Data is sampled from the synchronised data in the same cycle as the edge.
  - led_clk high and low phases must each be at least 3 clk cycles.
- Shifting: MSB first; shift_reg <= {shift_reg[30:0], bit}; bit_cnt counts 0..31.
- State HUNT:
  - Counts consecutive zero bits; any 1 bit resets the count.
  - On the 32nd consecutive zero: pulse frame_start, set pix_idx counter to 0, clear bit_cnt, go to WORD.
- State WORD: after the 32nd bit, the completed word w is decoded in the following cycle:
  - w == 0x00000000: new start frame. Pulse frame_start, reset index to 0, stay in WORD.
  - w == 0xFFFFFFFF: end frame. Pulse frame_end, go to HUNT. An all-ones pixel is therefore indistinguishable from an end frame, and is treated as an end frame.
  - w[31:29] == 3'b111: pixel. Fields are glo=w[28:24], blu=w[23:16], grn=w[15:8], red=w[7:0].
  - Any other value: protocol error. Go to HUNT.
- Pixel output:
  - A decoded pixel loads the output registers and sets valid one cycle after the 32nd edge.
  - The index counter increments after each pixel and saturates at all-ones.
  - If valid=1 and ack=0 when a new pixel decodes: the new pixel is dropped, overrun is set, and the index still increments.
  - If ack=1 in the same cycle a new pixel decodes: the old pixel transfers and the new one loads; valid stays 1.
  - Otherwise ack with valid clears valid on the next cycle. ack while valid=0 is ignored.
- Timeout:
  - An idle counter resets on each rising edge.
  - When it reaches TIMEOUT in WORD: discard any partial word, go to HUNT. The zero-run count restarts.
  - Any held pixel remains valid.
- Reset mid-word: the partial word is discarded, state returns to HUNT, and the held pixel is lost.

Optional Feature:
- Macro: LEDSTRING_RX_STATS_EN.
- When defined: adds output ports err_cnt[7:0] (protocol errors plus timeouts with bit_cnt != 0), drop_cnt[7:0] (overrun drops) and frame_cnt[15:0] (end frames).
  - All three counters saturate and reset to 0.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package ledstring_pkg holds:
  - Word constants: START_WORD=32'h00000000, END_WORD=32'hFFFFFFFF, PIX_HDR=3'b111.
  - Field bit-position localparams.
  - State encoding: HUNT, WORD.
- Natural sub-module: ledstring_rx_sync, the synchroniser plus edge detector. It outputs bit_stb and bit_val.

Test Plan:
- Start frame, then words 0xFFEE55AA and 0xFF9944DD, then 0xFFFFFFFF, with ack held 1:
  - frame_start pulses once.
  - First pixel: glo=1F, blu=EE, grn=55, red=AA, idx=0.
  - Second pixel: blu=99, grn=44, red=DD, idx=1.
  - frame_end pulses once.
- Send 16 pixels with ack=0, then pulse ack:
  - The first pixel (idx=0) is held.
  - overrun=1; drop_cnt=15 when LEDSTRING_RX_STATS_EN is defined.
  - valid=0 one cycle after ack.
- 31 zero bits, then a 1, then 32 zeros, then a pixel: exactly one frame_start, only after the second run; the pixel gets idx=0.
- Start frame, then word 0x5A000000: no valid; state returns to HUNT; err_cnt=1 when stats are enabled.
- Start frame, 12 pixel bits, then led_clk idle for 1024 cycles, then a new start frame and pixel 0xE1010203:
  - Pixel glo=01, blu=01, grn=02, red=03, idx=0.
  - No spurious valid from the partial word.
- Assert rst for 1 cycle in the middle of a pixel word: all outputs 0 the next cycle; the stream resumes only after a fresh 32-zero start frame.
